st_pixel_unpacker: RTL and testbench

Streaming width converter that sits directly downstream of the mSGDMA streaming source (256-bit Avalon-ST) in the FPGA fabric. It accepts full-width DMA beats and serialises each beat into 32-bit pixels, lane 0 first, with Avalon-ST style ready/valid handshakes on both sides. Pixel position counters tag each output pixel with start-of-frame and end-of-line markers for the HDMI output path.

---
 rtl/st_pixel_unpacker_if.sv | 34 +++
 rtl/st_pixel_unpacker.sv | 146 ++++++++++++++
 tb/tb_st_pixel_unpacker.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/st_pixel_unpacker_if.sv
// Ready/valid streaming bus used on both sides of st_pixel_unpacker.
//
// Parameters:
//   DW    - data width of the stream
// Signals:
//   data  - payload, qualified by valid
//   valid - source has a transfer on offer
//   ready - sink can take the transfer this cycle
// A transfer happens on a rising clock edge where valid && ready.
// Modports:
//   master - drives data/valid, observes ready
//   slave  - observes data/valid, drives ready

interface st_pixel_unpacker_if #(
  parameter int unsigned DW = 32
);

  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/st_pixel_unpacker.sv
// st_pixel_unpacker
//
// Width converter between the mSGDMA 256-bit streaming source and the
// 32-bit HDMI pixel path. Each accepted input beat is held and replayed as
// IN_DW/OUT_DW pixels, lane 0 (least significant) first. Position counters
// tag pixels with start-of-frame and end-of-line markers.
//
// Parameters:
//   IN_DW     - input beat width, integer multiple of OUT_DW
//   OUT_DW    - pixel width (RGBX, X in [31:24])
//   H_ACTIVE  - pixels per line
//   V_ACTIVE  - lines per frame
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   st        - input beat stream (slave side, IN_DW wide)
//   px        - output pixel stream (master side, OUT_DW wide)
//   px_sof    - current pixel is (0,0) of a frame, qualified by px.valid
//   px_eol    - current pixel is last of its line, qualified by px.valid
//
// Build option:
//   ST_UNPACK_FRAME_MARK_EN - when defined, builds the h/v position
//   counters that drive px_sof/px_eol. When undefined, both markers are
//   tied low; data path and handshakes are identical.

module st_pixel_unpacker #(
  parameter int unsigned IN_DW    = 256,
  parameter int unsigned OUT_DW   = 32,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720
) (
  input  logic                 clk,
  input  logic                 rst,
  st_pixel_unpacker_if.slave   st,
  st_pixel_unpacker_if.master  px,
  output logic                 px_sof,
  output logic                 px_eol
);

  localparam int unsigned LANES = IN_DW / OUT_DW;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

  // Reject configurations the lane slicing cannot represent.
  if ((OUT_DW == 0) || (IN_DW % OUT_DW != 0) || (LANES < 1) ||
      (H_ACTIVE < 1) || (V_ACTIVE < 1)) begin : g_param_check
    $error("st_pixel_unpacker: illegal parameter combination");
  end

  // ---------------------------------------------------------------------
  // Beat holding register and lane sequencer
  // ---------------------------------------------------------------------
  logic [IN_DW-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [LW-1:0]    lane_q, lane_d;

  logic last_lane;
  logic px_fire;
  logic st_fire;

  always_comb begin
    last_lane = (lane_q == LastLane);
    px_fire   = full_q && px.ready;
    // The last-lane handshake frees the register in the same cycle, so a
    // waiting beat can load with no bubble. This makes px.ready -> st.ready
    // a combinational path. Held low during reset so no beat slips in.
    st.ready  = !rst && (!full_q || (px_fire && last_lane));
    st_fire   = st.valid && st.ready;

    px.valid  = full_q;
    px.data   = hold_q[lane_q*OUT_DW +: OUT_DW];
  end

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    lane_d = lane_q;
    if (st_fire) begin
      // Covers both the empty case and the last-lane overlap case.
      hold_d = st.data;
      full_d = 1'b1;
      lane_d = '0;
    end else if (px_fire) begin
      if (last_lane) begin
        full_d = 1'b0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
      lane_q <= '0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
      lane_q <= lane_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame position markers
  // ---------------------------------------------------------------------
`ifdef ST_UNPACK_FRAME_MARK_EN
  localparam int unsigned HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [HW-1:0] HLast = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] VLast = VW'(V_ACTIVE - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    // Position tracks pixels actually consumed downstream.
    if (px_fire) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
    px_sof = (h_cnt_q == '0) && (v_cnt_q == '0);
    px_eol = (h_cnt_q == HLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end
`else
  assign px_sof = 1'b0;
  assign px_eol = 1'b0;
`endif

endmodule

// File: tb/tb_st_pixel_unpacker.sv
// Testbench for st_pixel_unpacker (H_ACTIVE=16, V_ACTIVE=4, 256->32 bit).
// Stimulus pushes expected pixels into a queue when a beat is accepted; a
// negedge monitor pops and compares whenever a pixel handshake occurs.

module tb_st_pixel_unpacker;

  localparam int unsigned IN_DW  = 256;
  localparam int unsigned OUT_DW = 32;
  localparam int unsigned LANES  = IN_DW / OUT_DW;
  localparam int unsigned H_ACT  = 16;
  localparam int unsigned V_ACT  = 4;

  typedef struct {
    logic [OUT_DW-1:0] data;
    logic              sof;
    logic              eol;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic px_sof, px_eol;

  always #5 clk = ~clk;

  st_pixel_unpacker_if #(.DW(IN_DW))  st_bus ();
  st_pixel_unpacker_if #(.DW(OUT_DW)) px_bus ();

  st_pixel_unpacker #(
    .IN_DW    (IN_DW),
    .OUT_DW   (OUT_DW),
    .H_ACTIVE (H_ACT),
    .V_ACTIVE (V_ACT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st_bus),
    .px     (px_bus),
    .px_sof (px_sof),
    .px_eol (px_eol)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pixel index -> frame position
  px_t exp_q[$];
  int  pix_idx = 0;

  function automatic void push_beat(input logic [IN_DW-1:0] d);
    for (int k = 0; k < int'(LANES); k++) begin
      px_t p;
      int  h, v;
      h = pix_idx % H_ACT;
      v = (pix_idx / H_ACT) % V_ACT;
      p.data = d[k*OUT_DW +: OUT_DW];
`ifdef ST_UNPACK_FRAME_MARK_EN
      p.sof = (h == 0) && (v == 0);
      p.eol = (h == H_ACT - 1);
`else
      p.sof = 1'b0;
      p.eol = 1'b0;
`endif
      exp_q.push_back(p);
      pix_idx++;
    end
  endfunction

  // Monitor state
  int   phase    = 0;
  int   cycle    = 0;
  int   last_acc = -1;
  int   pops_p2  = 0;
  int   gap_cnt  = 0;
  int   sof_cnt  = 0;
  int   eol_cnt  = 0;
  logic prev_rst = 1'b0;
  logic stall_v  = 1'b0;
  logic [OUT_DW-1:0] stall_data;
  logic stall_sof, stall_eol;
  int   rdy_mode = 0;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      check("st_ready_in_reset", 64'(st_bus.ready), 64'd0);
      exp_q.delete();
      pix_idx  = 0;
      stall_v  = 1'b0;
      prev_rst = 1'b1;
    end else begin
      logic exp_ready;
      if (prev_rst) begin
        check("post_reset_px_valid", 64'(px_bus.valid), 64'd0);
        check("post_reset_px_data", 64'(px_bus.data), 64'd0);
`ifdef ST_UNPACK_FRAME_MARK_EN
        check("post_reset_px_sof", 64'(px_sof), 64'd1);
`else
        check("post_reset_px_sof", 64'(px_sof), 64'd0);
`endif
        check("post_reset_px_eol", 64'(px_eol), 64'd0);
      end
      prev_rst = 1'b0;

      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && px_bus.ready);
      check("st_ready", 64'(st_bus.ready), 64'(exp_ready));
      check("px_valid", 64'(px_bus.valid), 64'(exp_q.size() != 0));

      if (stall_v) begin
        check("stall_data", 64'(px_bus.data), 64'(stall_data));
        check("stall_sof", 64'(px_sof), 64'(stall_sof));
        check("stall_eol", 64'(px_eol), 64'(stall_eol));
      end
      stall_v    = px_bus.valid && !px_bus.ready;
      stall_data = px_bus.data;
      stall_sof  = px_sof;
      stall_eol  = px_eol;

      if (phase == 2 && pops_p2 > 0 && pops_p2 < 128 && !px_bus.valid) gap_cnt++;

      if (px_bus.valid && px_bus.ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 64'd1, 64'd0);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          check("px_data", 64'(px_bus.data), 64'(e.data));
          check("px_sof", 64'(px_sof), 64'(e.sof));
          check("px_eol", 64'(px_eol), 64'(e.eol));
        end
        if (phase == 2) pops_p2++;
        if (phase == 4 && px_sof) sof_cnt++;
        if (phase == 4 && px_eol) eol_cnt++;
      end

      if (st_bus.valid && st_bus.ready) begin
        push_beat(st_bus.data);
        if (phase == 2 && last_acc >= 0) check("beat_spacing", 64'(cycle - last_acc), 64'd8);
        last_acc = cycle;
      end
    end
  end

  // Downstream ready driver
  initial begin
    px_bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_bus.ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end
  end

  function automatic logic [IN_DW-1:0] rand_beat();
    logic [IN_DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[i*OUT_DW +: OUT_DW] = $urandom;
    return r;
  endfunction

  task automatic send_beat(input logic [IN_DW-1:0] d);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    st_bus.data  = d;
    st_bus.valid = 1'b1;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = st_bus.ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("beat_accept_timeout", 64'd0, 64'd1);
    st_bus.valid = 1'b0;
    st_bus.data  = rand_beat();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || px_bus.valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [IN_DW-1:0] d;
    st_bus.valid = 1'b0;
    st_bus.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, lane k = k
    phase = 1;
    for (int k = 0; k < int'(LANES); k++) d[k*OUT_DW +: OUT_DW] = 32'(k);
    send_beat(d);
    wait_drain();

    // Continuous beats, px_ready held high
    phase    = 2;
    last_acc = -1;
    for (int b = 0; b < 16; b++) send_beat(rand_beat());
    wait_drain();
    phase = 0;
    check("cont_pixel_count", 64'(pops_p2), 64'd128);
    check("cont_gap_cycles", 64'(gap_cnt), 64'd0);

    // Frame markers: 9 beats = 72 pixels, wraps into second frame
    pulse_reset();
    phase = 4;
    for (int b = 0; b < 9; b++) send_beat(rand_beat());
    wait_drain();
    phase = 0;
`ifdef ST_UNPACK_FRAME_MARK_EN
    check("frame_sof_count", 64'(sof_cnt), 64'd2);
    check("frame_eol_count", 64'(eol_cnt), 64'd4);
`else
    check("frame_sof_count", 64'(sof_cnt), 64'd0);
    check("frame_eol_count", 64'(eol_cnt), 64'd0);
`endif

    // Reset after three pixels of a beat; remaining lanes must vanish
    send_beat(rand_beat());
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pulse_reset();
    for (int k = 0; k < int'(LANES); k++) d[k*OUT_DW +: OUT_DW] = 32'h100 + 32'(k);
    send_beat(d);
    wait_drain();

    // Random source gaps and random downstream backpressure
    rdy_mode = 1;
    for (int b = 0; b < 1000; b++) begin
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
      send_beat(rand_beat());
    end
    wait_drain();
    rdy_mode = 0;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
